// File: rtl/modcounter_pkg.sv
// Shared constants and helpers for the up/down modulus counter.
package modcounter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A stored modulus of 0 stands for 2^width.
  function automatic logic [32:0] mod_decode(input logic [31:0] mod_val, input int unsigned width);
    if (mod_val == 32'd0) begin
      return 33'd1 << width;
    end
    return {1'b0, mod_val};
  endfunction

endpackage

// File: rtl/modcounter_modreg.sv
// Holds the modulus in effect plus a pending modulus that is applied at the next wrap or load.
module modcounter_modreg
  import modcounter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_MOD = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             wrap_i,
  input  logic             mod_wr_i,
  input  logic [WIDTH-1:0] mod_val_i,
  output logic [WIDTH-1:0] mod_cur_o,
  output logic [WIDTH-1:0] mod_nxt_o
);

  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;

  always_comb begin
    mod_d      = mod_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (load_i) begin
      // A write in the same cycle as a load is applied immediately.
      if (mod_wr_i) begin
        mod_d = mod_val_i;
      end else if (pend_vld_q) begin
        mod_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (wrap_i) begin
      if (pend_vld_q) begin
        mod_d = pend_q;
      end
      pend_vld_d = mod_wr_i;
      if (mod_wr_i) begin
        pend_d = mod_val_i;
      end
    end else if (mod_wr_i) begin
      pend_d     = mod_val_i;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mod_q      <= WIDTH'(DEFAULT_MOD);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      mod_q      <= mod_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  assign mod_cur_o = mod_q;
  assign mod_nxt_o = mod_d;

endmodule

// File: rtl/updown_modcounter.sv
// Up/down modulus counter with deferred modulus update and load clamping.
// Optional wrap event counter enabled by macro UPDOWN_MODCOUNTER_WRAPCNT_EN.
module updown_modcounter
  import modcounter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] mod_cur,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
`ifdef UPDOWN_MODCOUNTER_WRAPCNT_EN
  ,
  output logic [15:0]      wrap_cnt
`endif
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, load_err_q, load_err_d;
  logic [WIDTH-1:0] mod_nxt;
  logic [WIDTH-1:0] last_cur, last_nxt;
  logic [WIDTH:0]   m_nxt;
  logic             wrap_ev;

  modcounter_modreg #(
    .WIDTH       (WIDTH),
    .DEFAULT_MOD (DEFAULT_MOD)
  ) u_modreg (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (load),
    .wrap_i    (wrap_ev),
    .mod_wr_i  (mod_wr),
    .mod_val_i (mod_val),
    .mod_cur_o (mod_cur),
    .mod_nxt_o (mod_nxt)
  );

  // M-1 in WIDTH bits; a stored 0 naturally yields all ones.
  assign last_cur = mod_cur - 1'b1;
  assign last_nxt = mod_nxt - 1'b1;
  assign m_nxt    = (WIDTH+1)'(mod_decode(32'(mod_nxt), WIDTH));

  assign tc      = en & (((up == DIR_UP) & (out_q == last_cur)) |
                         ((up == DIR_DOWN) & (out_q == '0)));
  assign wrap_ev = tc & ~load;

  always_comb begin
    out_d      = out_q;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, load_val} >= m_nxt) begin
        out_d      = last_nxt;
        load_err_d = 1'b1;
      end else begin
        out_d = load_val;
      end
    end else if (en) begin
      // Down-wrap target uses the modulus being applied on this same edge.
      if (wrap_ev) begin
        out_d = (up == DIR_UP) ? '0 : last_nxt;
      end else begin
        out_d = (up == DIR_UP) ? out_q + 1'b1 : out_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      wrap_q     <= wrap_ev;
      load_err_q <= load_err_d;
    end
  end

`ifdef UPDOWN_MODCOUNTER_WRAPCNT_EN
  logic [15:0] wrap_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt_q <= '0;
    end else if (wrap_ev) begin
      wrap_cnt_q <= wrap_cnt_q + 16'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

  assign out      = out_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_updown_modcounter.sv
// Randomised and directed bench for updown_modcounter against an arithmetic reference model.
module tb_updown_modcounter;

  logic       clk = 1'b0;
  logic       rst, en, up, load, mod_wr;
  logic [3:0] load_val, mod_val;
  logic [3:0] out, mod_cur;
  logic       tc, wrap, load_err;
`ifdef UPDOWN_MODCOUNTER_WRAPCNT_EN
  logic [15:0] wrap_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers, modulus kept in its stored encoding.
  int  m_out, m_mod, m_pend, m_wc;
  bit  m_pv, m_wrap, m_err;

  updown_modcounter #(
    .WIDTH       (4),
    .DEFAULT_MOD (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .mod_wr   (mod_wr),
    .mod_val  (mod_val),
    .out      (out),
    .mod_cur  (mod_cur),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
`ifdef UPDOWN_MODCOUNTER_WRAPCNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int m);
    return (m == 0) ? 16 : m;
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv,
                      input bit w, input int mv);
    int  mm;
    bit  hit;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; mod_wr = w;
    load_val = 4'(lv); mod_val = 4'(mv);
    #1;
    mm  = eff(m_mod);
    hit = e && ((u && m_out == mm - 1) || (!u && m_out == 0));
    check("tc", 32'(tc), 32'(hit));
    if (r) begin
      m_out = 0; m_mod = 10; m_pv = 0; m_pend = 0; m_wrap = 0; m_err = 0; m_wc = 0;
    end else if (l) begin
      m_mod  = w ? mv : (m_pv ? m_pend : m_mod);
      m_pv   = 0;
      mm     = eff(m_mod);
      m_err  = (lv >= mm);
      m_out  = m_err ? mm - 1 : lv;
      m_wrap = 0;
    end else begin
      m_err  = 0;
      m_wrap = hit;
      if (hit) begin
        if (m_pv) m_mod = m_pend;
        m_pv = w;
        if (w) m_pend = mv;
        mm    = eff(m_mod);
        m_out = u ? 0 : mm - 1;
        m_wc  = (m_wc + 1) % 65536;
      end else begin
        if (w) begin
          m_pend = mv;
          m_pv   = 1;
        end
        if (e) m_out = u ? (m_out + 1) % mm : (m_out + mm - 1) % mm;
      end
    end
    @(posedge clk);
    #1;
    check("out", 32'(out), 32'(m_out));
    check("mod_cur", 32'(mod_cur), 32'(m_mod % 16));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic idle_up(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; mod_wr = 1'b0;
    load_val = '0; mod_val = '0;
    m_out = 0; m_mod = 10; m_pv = 0; m_pend = 0; m_wrap = 0; m_err = 0; m_wc = 0;

    // Reset state, then 12 up counts through one wrap.
    step(1, 0, 1, 0, 0, 0, 0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_mod", 32'(mod_cur), 32'd10);
    idle_up(9);
    check("up_at9", 32'(out), 32'd9);
    idle_up(1);
    check("up_wrap_out", 32'(out), 32'd0);
    check("up_wrap_pulse", 32'(wrap), 32'd1);
    idle_up(2);
    check("up_wrap_gone", 32'(wrap), 32'd0);

    // Down-wrap from 0, then with 2^WIDTH modulus.
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("down_wrap_out", 32'(out), 32'd9);
    check("down_wrap_pulse", 32'(wrap), 32'd1);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("down_m16", 32'(out), 32'd15);

    // Deferred modulus write at out=3.
    step(1, 0, 1, 0, 0, 0, 0);
    idle_up(2);
    step(0, 1, 1, 0, 0, 1, 5);
    check("pend_not_yet", 32'(mod_cur), 32'd10);
    idle_up(7);
    check("pend_applied", 32'(mod_cur), 32'd5);
    idle_up(5);
    check("new_m_wrap", 32'(out), 32'd0);

    // Load clamping.
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 12, 0, 0);
    check("clamp_out", 32'(out), 32'd9);
    check("clamp_err", 32'(load_err), 32'd1);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 7, 0, 0);
    check("load7", 32'(out), 32'd7);

    // Reset overrides load, mod_wr and en.
    idle_up(1);
    step(1, 1, 1, 1, 5, 1, 3);
    check("rst_ovr_out", 32'(out), 32'd0);
    idle_up(10);
    check("rst_ovr_mod", 32'(mod_cur), 32'd10);

    // Modulus 1 holds at 0 and wraps every enabled cycle.
    step(0, 0, 1, 1, 0, 1, 1);
    idle_up(3);
    step(0, 1, 0, 0, 0, 0, 0);

    // Random traffic.
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0, $urandom % 2, ($urandom % 10) == 0,
           int'($urandom % 16), ($urandom % 8) == 0, int'($urandom % 16));
    end

`ifdef UPDOWN_MODCOUNTER_WRAPCNT_EN
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 1);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; mod_wr = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("wrap_cnt", 32'(wrap_cnt), 32'd4464);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
